// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit bidirectional uio pad bus between NREQ
// requesters, with an idle turnaround window whenever the pad direction flips.
module uio_bus_arbiter #(
    parameter int NREQ      = 4,
    parameter int TURN      = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_dir,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rdata,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    input  logic [7:0]        uio_in
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [PW-1:0]     ptr_r, ptr_s;
    logic [NREQ-1:0]   gnt_r, gnt_s;
    logic              bus_dir_r, bus_dir_s;
    logic              dir_r, dir_s;
    logic [1:0]        turn_cnt_r, turn_cnt_s;
    logic [BW-1:0]     beat_cnt_r, beat_cnt_s;
    logic [7:0]        last_byte_r, last_byte_s;

    logic              win_found_s;
    logic [PW-1:0]     win_idx_s;
    logic [NREQ-1:0]   win_onehot_s;
    logic              req_own_s;
    logic [7:0]        wdata_own_s;

    // Ptr_r always names the owner while a grant is live
    assign req_own_s   = req[ptr_r];
    assign wdata_own_s = req_wdata[{ptr_r, 3'b000} +: 8];

    // Round-robin search starting just after the last granted index
    always_comb begin
        int  idx_v;
        logic hit_v;
        win_found_s = 1'b0;
        win_idx_s   = {PW{1'b0}};
        idx_v       = 0;
        hit_v       = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_v       = (int'(ptr_r) + k) % NREQ;
            hit_v       = !win_found_s && req[PW'(idx_v)];
            win_idx_s   = hit_v ? PW'(idx_v) : win_idx_s;
            win_found_s = win_found_s | hit_v;
        end
        win_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
    end

    // Next-state logic for the grant FSM and its counters
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        gnt_s       = gnt_r;
        bus_dir_s   = bus_dir_r;
        dir_s       = dir_r;
        turn_cnt_s  = turn_cnt_r;
        beat_cnt_s  = beat_cnt_r;
        last_byte_s = last_byte_r;
        case (state_r)
            ST_IDLE: begin
                if (ena && win_found_s) begin
                    ptr_s      = win_idx_s;
                    gnt_s      = win_onehot_s;
                    dir_s      = req_dir[win_idx_s];
                    beat_cnt_s = {BW{1'b0}};
                    // Direction is committed to the pads only once XFER starts
                    if ((req_dir[win_idx_s] != bus_dir_r) && (TURN > 0)) begin
                        state_s    = ST_TURN;
                        turn_cnt_s = 2'(TURN - 1);
                    end else begin
                        state_s   = ST_XFER;
                        bus_dir_s = req_dir[win_idx_s];
                    end
                end else begin
                    gnt_s = {NREQ{1'b0}};
                end
            end
            ST_TURN: begin
                if (!req_own_s) begin
                    state_s = ST_IDLE;
                    gnt_s   = {NREQ{1'b0}};
                end else if (turn_cnt_r == 2'd0) begin
                    state_s    = ST_XFER;
                    bus_dir_s  = dir_r;
                    beat_cnt_s = {BW{1'b0}};
                end else begin
                    turn_cnt_s = turn_cnt_r - 2'd1;
                end
            end
            ST_XFER: begin
                if (!req_own_s) begin
                    state_s = ST_IDLE;
                    gnt_s   = {NREQ{1'b0}};
                end else begin
                    // Remember the byte so the parked bus keeps showing it
                    if (bus_dir_r) begin
                        last_byte_s = wdata_own_s;
                    end else begin
                        last_byte_s = last_byte_r;
                    end
                    if (beat_cnt_r == BW'(MAX_BURST - 1)) begin
                        state_s = ST_IDLE;
                        gnt_s   = {NREQ{1'b0}};
                    end else begin
                        beat_cnt_s = beat_cnt_r + {{(BW-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = {NREQ{1'b0}};
            end
        endcase
    end

    // State and grant registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= PW'(NREQ - 1);
            gnt_r       <= {NREQ{1'b0}};
            bus_dir_r   <= 1'b0;
            dir_r       <= 1'b0;
            turn_cnt_r  <= 2'd0;
            beat_cnt_r  <= {BW{1'b0}};
            last_byte_r <= 8'h00;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            gnt_r       <= gnt_s;
            bus_dir_r   <= bus_dir_s;
            dir_r       <= dir_s;
            turn_cnt_r  <= turn_cnt_s;
            beat_cnt_r  <= beat_cnt_s;
            last_byte_r <= last_byte_s;
        end
    end

    assign gnt     = gnt_r;
    assign ack     = ((state_r == ST_XFER) && req_own_s) ? gnt_r : {NREQ{1'b0}};
    assign rdata   = uio_in;
    // Pads stay driven while parked in write direction, released during turnaround
    assign uio_oe  = ((state_r != ST_TURN) && bus_dir_r) ? 8'hFF : 8'h00;
    assign uio_out = ((state_r == ST_XFER) && req_own_s && bus_dir_r) ? wdata_own_s : last_byte_r;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_uio_bus_arbiter;

    localparam int NREQ      = 4;
    localparam int TURN      = 1;
    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [3:0]  req;
    logic [3:0]  req_dir;
    logic [31:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic [7:0]  uio_in;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // Model: who owns the bus, how much turnaround remains, beats moved
    int         m_owner;
    int         m_wait;
    int         m_beats;
    int         m_last;
    bit         m_dir;
    bit         m_odir;
    logic [7:0] m_park;

    uio_bus_arbiter #(.NREQ(NREQ), .TURN(TURN), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .req_dir(req_dir),
        .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
        .uio_out(uio_out), .uio_oe(uio_oe), .uio_in(uio_in)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] e_gnt;
        logic [3:0] e_ack;
        logic [7:0] e_oe;
        logic [7:0] e_out;
        e_gnt = 4'b0000;
        e_ack = 4'b0000;
        e_oe  = m_dir ? 8'hFF : 8'h00;
        e_out = m_park;
        if (m_owner >= 0) begin
            e_gnt = 4'b0001 << m_owner;
            if (m_wait > 0) e_oe = 8'h00;
            else if (req[m_owner]) begin
                e_ack = e_gnt;
                if (m_dir) e_out = req_wdata[8*m_owner +: 8];
            end
        end
        cmp("gnt", 32'(gnt), 32'(e_gnt));
        cmp("ack", 32'(ack), 32'(e_ack));
        cmp("uio_oe", 32'(uio_oe), 32'(e_oe));
        cmp("uio_out", 32'(uio_out), 32'(e_out));
        cmp("rdata", 32'(rdata), 32'(uio_in));
    endtask

    task automatic model_step();
        if (rst) begin
            m_owner = -1; m_wait = 0; m_beats = 0; m_last = NREQ - 1;
            m_dir = 1'b0; m_odir = 1'b0; m_park = 8'h00;
        end else if (m_owner < 0) begin
            if (ena && (req != 4'b0000)) begin
                for (int k = NREQ; k >= 1; k--)
                    if (req[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
                m_last  = m_owner;
                m_odir  = req_dir[m_owner];
                m_beats = 0;
                if (m_odir != m_dir && TURN > 0) m_wait = TURN;
                else begin m_wait = 0; m_dir = m_odir; end
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_dir = m_odir;
        end else begin
            if (m_dir) m_park = req_wdata[8*m_owner +: 8];
            m_beats++;
            if (m_beats == MAX_BURST) m_owner = -1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        if (checking) check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        settle();
        adv();
        rst = 1'b0;
    endtask

    int         order[$];
    int         ack_cnt[4];
    logic [3:0] prev_gnt;
    logic [15:0] ack_mask;

    initial begin
        rst = 1'b1; ena = 1'b1; req = 4'b1111; req_dir = 4'b0000;
        req_wdata = 32'h0; uio_in = 8'h00;
        adv();
        checking = 1'b1;

        // Reset held with all requests high
        settle();
        cmp("rst_gnt", 32'(gnt), 32'h0);
        cmp("rst_ack", 32'(ack), 32'h0);
        cmp("rst_oe", 32'(uio_oe), 32'h00);
        cmp("rst_out", 32'(uio_out), 32'h00);
        adv();
        rst = 1'b0;

        // Round robin among four readers, first grant is req0
        prev_gnt = 4'b0000;
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        for (int n = 0; n < 26; n++) begin
            settle();
            if (n == 1) cmp("first_gnt", 32'(gnt), 32'h1);
            if (gnt != 4'b0000 && prev_gnt == 4'b0000)
                for (int i = 0; i < 4; i++) if (gnt[i]) order.push_back(i);
            for (int i = 0; i < 4; i++) if (ack[i]) ack_cnt[i]++;
            prev_gnt = gnt;
            adv();
        end
        cmp("rr_len", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < order.size()) cmp("rr_order", 32'(order[i]), 32'(i % 4));
        cmp("rr_ack0", 32'(ack_cnt[0]), 32'd8);
        cmp("rr_ack3", 32'(ack_cnt[3]), 32'd4);

        // Single write burst of three beats with turnaround
        req = 4'b0000;
        do_reset();
        req = 4'b0001; req_dir = 4'b0001; req_wdata = 32'h0000_00A5;
        for (int n = 0; n < 5; n++) begin
            settle();
            if (n == 1) begin
                cmp("wr_turn_gnt", 32'(gnt), 32'h1);
                cmp("wr_turn_oe", 32'(uio_oe), 32'h00);
                cmp("wr_turn_ack", 32'(ack), 32'h0);
            end
            if (n == 2 || n == 4) begin
                cmp("wr_ack", 32'(ack), 32'h1);
                cmp("wr_out", 32'(uio_out), 32'hA5);
                cmp("wr_oe", 32'(uio_oe), 32'hFF);
            end
            adv();
        end
        req = 4'b0000;
        settle(); adv();
        settle();
        cmp("park_oe", 32'(uio_oe), 32'hFF);
        cmp("park_out", 32'(uio_out), 32'hA5);
        cmp("park_gnt", 32'(gnt), 32'h0);
        adv();

        // Direction flip: writer req1 then reader req2
        req = 4'b0010; req_dir = 4'b0010; req_wdata = 32'h0000_3C00;
        for (int n = 0; n < 3; n++) begin settle(); adv(); end
        req = 4'b0100; uio_in = 8'hC3;
        for (int n = 3; n < 7; n++) begin
            settle();
            if (n == 5) begin
                cmp("flip_turn_gnt", 32'(gnt), 32'h4);
                cmp("flip_turn_oe", 32'(uio_oe), 32'h00);
                cmp("flip_turn_ack", 32'(ack), 32'h0);
            end
            if (n == 6) begin
                cmp("flip_ack", 32'(ack), 32'h4);
                cmp("flip_rdata", 32'(rdata), 32'hC3);
            end
            adv();
        end
        req = 4'b0000;
        for (int n = 0; n < 2; n++) begin settle(); adv(); end

        // Burst cap: lone reader held for ten beats
        req_dir = 4'b0000;
        ack_mask = 16'h0;
        for (int n = 0; n < 15; n++) begin
            req = (n <= 12) ? 4'b0001 : 4'b0000;
            settle();
            ack_mask[n] = ack[0];
            adv();
        end
        cmp("burst_mask", 32'(ack_mask), 32'h1BDE);

        // Requester drops during turnaround
        req = 4'b0001; req_dir = 4'b0001;
        settle(); adv();
        req = 4'b0000;
        settle(); cmp("drop_turn_gnt", 32'(gnt), 32'h1); adv();
        settle();
        cmp("drop_gnt", 32'(gnt), 32'h0);
        cmp("drop_oe", 32'(uio_oe), 32'h00);
        adv();

        // Reset during the second write beat clears grant and pointer
        req = 4'b1011; req_dir = 4'b0010; req_wdata = 32'h0000_5A00;
        for (int n = 0; n < 3; n++) begin settle(); adv(); end
        rst = 1'b1;
        settle(); cmp("mid_ack", 32'(ack), 32'h2); adv();
        rst = 1'b0;
        settle();
        cmp("mid_gnt", 32'(gnt), 32'h0);
        cmp("mid_oe", 32'(uio_oe), 32'h00);
        adv();
        settle(); cmp("mid_regrant", 32'(gnt), 32'h1); adv();
        req = 4'b0000;
        for (int n = 0; n < 2; n++) begin settle(); adv(); end

        // Enable low blocks new grants
        ena = 1'b0; req = 4'b0100; req_dir = 4'b0000;
        for (int n = 0; n < 3; n++) begin
            settle(); cmp("ena_block", 32'(gnt), 32'h0); adv();
        end
        ena = 1'b1;
        settle(); adv();
        settle(); cmp("ena_grant", 32'(gnt), 32'h4); adv();

        // Randomized traffic with occasional enable drops and resets
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    req[i] = ~req[i];
                    if (req[i]) req_dir[i] = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 15) == 0) req_dir[i] = ~req_dir[i];
            end
            req_wdata = $urandom;
            uio_in    = 8'($urandom);
            ena       = ($urandom_range(0, 9) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            settle();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uio_bus_arbiter.md
Name: uio_bus_arbiter

Overview:
- Shares the 8-bit bidirectional uio pad bus of the top-level user module between NREQ internal requesters.
- Each granted requester runs a burst of single-byte write beats (drives uio_out/uio_oe) or read beats (samples uio_in).
- Grants rotate round-robin.
- An idle turnaround window is inserted whenever bus direction flips, so pad drivers never fight an external device.
- Sits directly between core logic and the uio_in/uio_out/uio_oe pins of the top module.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TURN, 1, idle turnaround cycles on direction change (0..3; 0 = no turnaround).
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration (1..16).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset (top drives it as ~rst_n).
- ena  in  1  design enable; low blocks new grants.
- req  in  NREQ  per-requester request, held high for the whole burst.
- req_dir  in  NREQ  per-requester direction: 1 = write (drive pads), 0 = read.
- req_wdata  in  8*NREQ  write byte of requester i at bits [8i+7:8i].
- gnt  out  NREQ  one-hot registered grant.
- ack  out  NREQ  one-hot beat acknowledge; requester advances data / samples rdata in this cycle.
- rdata  out  8  read data, equal to uio_in (combinational pass-through); valid when ack is high on a read grant.
- uio_out  out  8  pad output data.
- uio_oe  out  8  pad output enable, all-ones or all-zeros only.
- uio_in  in  8  pad input data.

Behaviour:
- Internal state:
  - FSM states IDLE, TURN, XFER.
  - ptr, the last granted index (log2 NREQ bits); reset value NREQ-1, so req[0] has top priority after reset.
  - bus_dir, the current pad direction; reset value 0 (read).
  - turn_cnt and beat_cnt.
- Reset (rst high at a clk edge):
  - State goes to IDLE; gnt = 0, ack = 0, uio_oe = 0, uio_out = 0, bus_dir = 0, ptr = NREQ-1.
  - Reset mid-burst aborts the burst with no further ack.
- IDLE:
  - If ena=1 and any req is high, pick the first requester w with req high, scanning ptr+1, ptr+2, ... modulo NREQ.
  - Next edge: gnt = onehot(w), ptr = w.
  - If req_dir[w] != bus_dir and TURN > 0: go to TURN with turn_cnt = TURN-1. Otherwise go to XFER.
  - Otherwise stay in IDLE with gnt = 0.
- TURN:
  - uio_oe = 0, ack = 0.
  - Decrement turn_cnt each cycle; at 0, go to XFER.
  - If req[w] drops during TURN: go to IDLE, clear gnt, leave bus_dir unchanged.
- XFER:
  - On entry: bus_dir = req_dir[w], beat_cnt = 0.
  - Each cycle with req[w]=1: ack[w]=1 (combinational from state/gnt/req).
    - Write: uio_oe = 8'hFF, uio_out = req_wdata[w].
    - Read: uio_oe = 0, rdata = uio_in.
  - Each ack increments beat_cnt.
  - Leave to IDLE (clear gnt) at the edge after the ack with beat_cnt = MAX_BURST-1.
  - Leave to IDLE at the edge after any XFER cycle with req[w]=0 (that cycle has no ack).
- Pads outside XFER:
  - In IDLE with bus_dir=1: uio_oe = 8'hFF and uio_out holds the last written byte (bus parked).
  - Otherwise uio_oe = 0.
- Latency: request to first ack is 1 cycle (no direction change) or 1+TURN cycles.
- Back-to-back grants: the IDLE cycle between bursts is mandatory (1-cycle re-arbitration gap).
- ena behaviour: ena=0 only blocks exits from IDLE; an in-flight burst completes normally.
- Changes to req_dir[w] while granted are ignored until the next grant.
- Invariants: gnt and ack are always zero or one-hot; ack only on the granted bit.

Test Plan:
1. Reset: hold rst 2 cycles with all req high -> gnt=0, ack=0, uio_oe=0x00, uio_out=0x00; first grant after release is req0.
2. Single write: req0=1, req_dir0=1, wdata0=0xA5 for 3 beats, TURN=1 -> gnt0 at +1, oe=0 at +1, ack0 at +2..+4 with uio_out=0xA5, uio_oe=0xFF; bus parked 0xFF/0xA5 afterwards.
3. Round robin: req[3:0]=4'b1111, all read, MAX_BURST=4, held continuously -> grant order 0,1,2,3,0, exactly 4 acks each, one idle cycle between grants, no TURN cycles.
4. Direction flip: req1 write (0x3C) 2 beats, then req2 read with uio_in=0xC3 -> one TURN cycle with uio_oe=0 before ack2; rdata=0xC3 on ack2.
5. Burst cap and early drop: lone req0 held 10 cycles -> ack groups of 4, 4, 2 separated by single idle cycles; req0 dropped during TURN -> gnt clears next cycle, bus_dir unchanged.
6. Reset mid-burst and ena: rst during second write beat -> next cycle gnt=0, uio_oe=0, ptr reset; ena=0 with req pending -> no grant until ena=1.
